// File: rtl/page_stream_fifo_if.sv
// Handshake bundle for the page stream FIFO. It carries the ap_vld/ap_ack
// producer side, the consumer side and the debug occupancy outputs.
interface page_stream_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_vld;
    logic                  din_ack;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  dout_ack;
    logic [ADDR_BITS:0]    count;
    logic [ADDR_BITS:0]    max_count;

    // The FIFO itself sits on the slave side.
    modport slave (
        input  din, din_vld, dout_ack,
        output din_ack, dout, dout_vld, count, max_count
    );

    modport master (
        output din, din_vld, dout_ack,
        input  din_ack, dout, dout_vld, count, max_count
    );
endinterface

// File: rtl/page_stream_fifo.sv
// Elastic first-word-fall-through buffer between a page leaf interface and a
// user kernel stream, with occupancy and peak-occupancy debug outputs.
module page_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic clk,
    input  logic reset,
    page_stream_fifo_if.slave stream
);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count_q;
    logic [ADDR_BITS:0]    count_d;
    logic [ADDR_BITS:0]    max_q;
    logic [ADDR_BITS:0]    max_d;
    logic                  write;
    logic                  read;

    // Both handshake outputs come only from registered occupancy, so neither
    // side sees a combinational path from the other side's strobe.
    assign stream.din_ack   = (count_q != FULL_COUNT);
    assign stream.dout_vld  = (count_q != '0);
    assign stream.dout      = mem[rd_ptr];
    assign stream.count     = count_q;
    assign stream.max_count = max_q;

    assign write = stream.din_vld  & stream.din_ack;
    assign read  = stream.dout_vld & stream.dout_ack;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (write && !read) begin
            count_d = count_q + 1'b1;
        end else if (read && !write) begin
            count_d = count_q - 1'b1;
        end
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            max_q   <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    // NOTE: storage is not reset; contents are only observable behind a valid count, and a reset array costs a mux per bit.
    always_ff @(posedge clk) begin
        if (write && !reset) begin
            mem[wr_ptr] <= stream.din;
        end
    end
endmodule

// File: tb/tb_page_stream_fifo.sv
// Self-checking bench for page_stream_fifo: a table of directed vectors plus
// hand-written sequences, all cross-checked against a queue-based model.
module tb_page_stream_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AB    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    page_stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

    page_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk    (clk),
        .reset  (reset),
        .stream (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the queue holds exactly the words currently buffered.
    logic [DW-1:0] sb[$];
    int  m_count = 0;
    int  m_max = 0;
    bit  last_write;
    bit  last_read;

    typedef struct {
        logic          rst;
        logic          vld;
        logic [DW-1:0] din;
        logic          ack;
        int            exp_count;
        int            exp_max;
        logic          exp_dout_vld;
        logic          exp_din_ack;
        logic [DW-1:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        bit            w;
        bit            r;
        logic [DW-1:0] wdata;
        @(negedge clk);
        check("din_ack", 64'(bus.din_ack), 64'(m_count != DEPTH));
        check("dout_vld", 64'(bus.dout_vld), 64'(m_count != 0));
        check("count", 64'(bus.count), 64'(m_count));
        check("max_count", 64'(bus.max_count), 64'(m_max));
        w = bus.din_vld && (m_count != DEPTH);
        r = bus.dout_ack && (m_count != 0);
        wdata = bus.din;
        if (r && !reset) begin
            check("dout_order", 64'(bus.dout), 64'(sb[0]));
        end
        @(posedge clk);
        if (reset) begin
            sb.delete();
            w = 1'b0;
            r = 1'b0;
        end else begin
            if (r) void'(sb.pop_front());
            if (w) sb.push_back(wdata);
        end
        m_count = sb.size();
        if (m_count > m_max) m_max = m_count;
        if (reset) m_max = 0;
        last_write = w;
        last_read  = r;
        #1;
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [DW-1:0] d, input logic ack);
        reset       = rst;
        bus.din_vld = vld;
        bus.din     = d;
        bus.dout_ack = ack;
    endtask

    vec_t vecs[8];

    initial begin
        int sent;
        int rcvd;
        int cyc;

        drive(1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 32'h1111_1111, 1'b1, 0, 0, 1'b0, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1, 1, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 0, 1, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1, 1, 1'b1, 1'b1, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0, 2, 2, 1'b1, 1'b1, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1, 2, 1'b1, 1'b1, 32'h9ABC_DEF0};
        vecs[6] = '{1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1, 2, 1'b1, 1'b1, 32'h0BAD_F00D};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 0, 2, 1'b0, 1'b1, 32'h0};

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].din, vecs[i].ack);
            tick();
            check($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_max", i), 64'(bus.max_count), 64'(vecs[i].exp_max));
            check($sformatf("vec%0d_dout_vld", i), 64'(bus.dout_vld), 64'(vecs[i].exp_dout_vld));
            check($sformatf("vec%0d_din_ack", i), 64'(bus.din_ack), 64'(vecs[i].exp_din_ack));
            if (vecs[i].exp_dout_vld) begin
                check($sformatf("vec%0d_dout", i), 64'(bus.dout), 64'(vecs[i].exp_dout));
            end
        end

        // Fill to full, hold a word off, then free one slot.
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, DW'(i), 1'b0);
            tick();
        end
        check("full_count", 64'(bus.count), 64'd16);
        check("full_din_ack", 64'(bus.din_ack), 64'd0);
        drive(1'b0, 1'b1, 32'h10, 1'b0);
        tick();
        check("held_count", 64'(bus.count), 64'd16);
        check("held_head", 64'(bus.dout), 64'h0);
        drive(1'b0, 1'b1, 32'h10, 1'b1);
        tick();
        check("full_read_write_blocked", 64'(last_write), 64'd0);
        check("freed_din_ack", 64'(bus.din_ack), 64'd1);
        check("freed_count", 64'(bus.count), 64'd15);
        drive(1'b0, 1'b1, 32'h10, 1'b0);
        tick();
        check("refill_accepted", 64'(last_write), 64'd1);
        check("peak_max", 64'(bus.max_count), 64'd16);
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("drained_count", 64'(bus.count), 64'd0);

        // Steady state at occupancy 5 with both sides streaming.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, DW'(32'h200 + i), 1'b1);
            tick();
            check("steady_count", 64'(bus.count), 64'd5);
            check("steady_both_move", 64'(last_write && last_read), 64'd1);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) tick();

        // Random gaps across pointer wrap-around.
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        sent = 0;
        rcvd = 0;
        cyc = 0;
        while (rcvd < 40 && cyc < 2000) begin
            drive(1'b0, (sent < 40) && ($urandom_range(0, 3) != 0), DW'(sent), $urandom_range(0, 2) != 0);
            tick();
            if (last_write) sent++;
            if (last_read) rcvd++;
            cyc++;
        end
        check("random_all_received", 64'(rcvd), 64'd40);
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        check("random_final_count", 64'(bus.count), 64'd0);

        // Reset mid-stream discards buffered words.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, DW'(32'h300 + i), 1'b0);
            tick();
        end
        check("prereset_count", 64'(bus.count), 64'd9);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("midreset_count", 64'(bus.count), 64'd0);
        check("midreset_dout_vld", 64'(bus.dout_vld), 64'd0);
        check("midreset_max", 64'(bus.max_count), 64'd0);
        drive(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0);
        tick();
        check("post_reset_head", 64'(bus.dout), 64'hA5A5_A5A5);
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        check("post_reset_empty", 64'(bus.dout_vld), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/page_stream_fifo.md
# page_stream_fifo

Elastic buffer between a page's `leaf_interface` user-side output and the `user_kernel` input stream. It can equally sit on the kernel's output stream before it returns to the interface. It decouples the HLS ap_vld/ap_ack producer from the consumer with DEPTH words of storage, so short consumer stalls do not back-pressure the BFT leaf. It also exposes occupancy and a peak-occupancy register for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload width; matches the 32-bit page stream.
- `DEPTH`, 16: storage words; must be a power of two and at least 2.
- `ADDR_BITS`, 4: log2(DEPTH).

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `din`  in  DATA_WIDTH: upstream data word.
- `din_vld`  in  1: upstream word valid.
- `din_ack`  out  1: block accepts the word this cycle.
- `dout`  out  DATA_WIDTH: head-of-queue word.
- `dout_vld`  out  1: `dout` holds a valid word.
- `dout_ack`  in  1: downstream consumes the word this cycle.
- `count`  out  ADDR_BITS+1: current occupancy, 0..DEPTH.
- `max_count`  out  ADDR_BITS+1: highest occupancy since reset.

## Operation
- Transfer rule, both sides: a word moves only when vld and ack are high in the same cycle.
  - `write = din_vld & din_ack`.
  - `read = dout_vld & dout_ack`.
  - `din_ack` and `dout_vld` do not depend combinationally on `din_vld` or `dout_ack`.
- `din_ack = (count != DEPTH)`. It is low only when full; the ack level carries no meaning while `din_vld` is low.
- `dout_vld = (count != 0)`. `dout = mem[rd_ptr]`, read asynchronously from the register array (first-word fall-through).
- Write: `mem[wr_ptr] <= din`, then `wr_ptr <= wr_ptr + 1`.
- Read: `rd_ptr <= rd_ptr + 1`.
- Pointers are ADDR_BITS wide and wrap modulo DEPTH with no special case.
- `count` next value:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- Simultaneous write and read while full cannot occur, because `din_ack` is low when full. A read while full frees a slot that is used on the following cycle.
- Simultaneous write and read while empty cannot occur, because `dout_vld` is low when empty. A word written into an empty FIFO is readable on the following cycle.
- `max_count <= max(max_count, next count)` every cycle. It saturates at DEPTH.
- No overflow or underflow is possible through the ports. `dout` is don't-care while `dout_vld` is low.
- Strict FIFO order: words leave in the order they were accepted, with no loss and no duplication.

## Timing
- Reset, synchronous and active-high: on any rising edge with `reset`=1:
  - `wr_ptr`, `rd_ptr`, `count` and `max_count` clear to 0.
  - Therefore `dout_vld`=0 and `din_ack`=1 from the next cycle.
  - Memory contents are not cleared.
- Reset dominates: a write or read in the reset cycle is discarded.
- Reset mid-operation: all buffered words are lost. No `dout_vld` pulse follows the reset edge.
- Latency from write accept at edge N to `dout_vld`=1 is 1 cycle, valid in cycle N+1 when previously empty.
- Latency from a read while full at edge N to `din_ack`=1 is 1 cycle.
- Throughput: one word per cycle sustained in steady state with 0 < count < DEPTH.
- `count` and `max_count` are registered and reflect transfers up to the previous edge.

## Test plan
- Reset with `din_vld`=1 and `dout_ack`=1 held high → after the reset edge: `count`=0, `max_count`=0, `dout_vld`=0, `din_ack`=1; nothing is written.
- Single word 0xDEADBEEF accepted at edge N, `dout_ack`=0 → cycle N+1: `dout_vld`=1, `dout`=0xDEADBEEF, `count`=1. Raise `dout_ack` → after the next edge: `dout_vld`=0, `count`=0.
- Write 0x00..0x0F with `dout_ack`=0 → `count`=16, `din_ack`=0. Word 0x10 is held, not accepted. One read → 0x00 out, `din_ack`=1 next cycle, then 0x10 is accepted. `max_count`=16.
- Prefill to 5, then drive `din_vld`=1 and `dout_ack`=1 for 20 cycles → `count` stays 5 and one word moves per cycle each side.
- Stream 40 sequential words (0..39) with random `din_vld`/`dout_ack` gaps, DEPTH=16 → output sequence exactly 0..39 across pointer wrap-around; final `count`=0.
- Fill to 9, assert `reset` for one cycle mid-stream → `count`=0, `dout_vld`=0, `max_count`=0. The next written word 0xA5A5A5A5 is the first one out.
